// File: rtl/ppu_pkg.sv
// Shared control-word field map and forwarding-select encodings for the PPU pipeline.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ppu_pkg;

    localparam int CW_W  = 22;
    localparam int RA_W  = 5;
    localparam int CNT_W = 16;

    // Control-word field indices
    localparam int ALUOP_LSB   = 0;
    localparam int ALUOP_W     = 4;
    localparam int ALUSRC_BIT  = 4;
    localparam int REGDST_LSB  = 5;
    localparam int REGDST_W    = 2;
    localparam int MEM2REG_BIT = 7;
    localparam int STORE_BIT   = 8;
    localparam int RFEN_BIT    = 9;
    localparam int LOAD_BIT    = 10;
    localparam int BRANCH_BIT  = 11;
    localparam int JUMP_BIT    = 12;
    localparam int LINK_BIT    = 13;

    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b01;
    localparam fwd_sel_t FWD_WB  = 2'b10;

endpackage

// File: rtl/ppu_hazard_unit.sv
// Load-use interlock, taken-branch flush and EX operand forwarding selects.
// Latency: purely combinational, valid in the same cycle.
// Backpressure: stall holds PC and IF/ID; flush takes priority for the EX bubble.
module ppu_hazard_unit #(
    parameter int RA_W       = ppu_pkg::RA_W,
    parameter int DELAY_SLOT = 1
) (
    input  logic            ex_load,
    input  logic            ex_rfen,
    input  logic [RA_W-1:0] ex_dest,
    input  logic [RA_W-1:0] ex_rs,
    input  logic [RA_W-1:0] ex_rt,
    input  logic            mem_rfen,
    input  logic [RA_W-1:0] mem_dest,
    input  logic            wb_rfen,
    input  logic [RA_W-1:0] wb_dest,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            ex_branch_taken,
    output logic            stall,
    output logic            ifid_flush,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel
);
    import ppu_pkg::*;

    logic mem_wr, wb_wr;
    logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

    // Writes to r0 are architecturally discarded, so they never interlock or forward
    assign mem_wr = mem_rfen && (mem_dest != '0);
    assign wb_wr  = wb_rfen  && (wb_dest  != '0);

    assign stall = ex_load && ex_rfen && (ex_dest != '0)
                   && ((ex_dest == id_rs) || (ex_dest == id_rt));

    assign ifid_flush = ex_branch_taken && (DELAY_SLOT == 0);

    assign mem_hit_a = mem_wr && (mem_dest == ex_rs);
    assign mem_hit_b = mem_wr && (mem_dest == ex_rt);
    assign wb_hit_a  = wb_wr  && (wb_dest  == ex_rs);
    assign wb_hit_b  = wb_wr  && (wb_dest  == ex_rt);

    always_comb begin
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (mem_hit_a)     fwd_a_sel = FWD_MEM;
        else if (wb_hit_a) fwd_a_sel = FWD_WB;
        if (mem_hit_b)     fwd_b_sel = FWD_MEM;
        else if (wb_hit_b) fwd_b_sel = FWD_WB;
    end

endmodule

// File: rtl/ppu_ctrl_pipe.sv
// Carries decoded control words ID->EX->MEM->WB with hazard control and event counters.
// Latency: ID to EX/MEM/WB in 1/2/3 cycles; hazard outputs combinational.
// Backpressure: stall or flush loads a bubble into EX; MEM/WB always advance.
module ppu_ctrl_pipe #(
    parameter int CW_W       = ppu_pkg::CW_W,
    parameter int RA_W       = ppu_pkg::RA_W,
    parameter int LOAD_BIT   = ppu_pkg::LOAD_BIT,
    parameter int RFEN_BIT   = ppu_pkg::RFEN_BIT,
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = ppu_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CW_W-1:0]  id_cw,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_dest,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             ifid_flush,
    output logic [CW_W-1:0]  ex_cw,
    output logic [CW_W-1:0]  mem_cw,
    output logic [CW_W-1:0]  wb_cw,
    output logic [RA_W-1:0]  ex_dest,
    output logic [RA_W-1:0]  mem_dest,
    output logic [RA_W-1:0]  wb_dest,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    import ppu_pkg::*;

    logic [RA_W-1:0] ex_rs, ex_rt;
    logic            bubble;

    ppu_hazard_unit #(
        .RA_W       (RA_W),
        .DELAY_SLOT (DELAY_SLOT)
    ) u_hazard (
        .ex_load         (ex_cw[LOAD_BIT]),
        .ex_rfen         (ex_cw[RFEN_BIT]),
        .ex_dest         (ex_dest),
        .ex_rs           (ex_rs),
        .ex_rt           (ex_rt),
        .mem_rfen        (mem_cw[RFEN_BIT]),
        .mem_dest        (mem_dest),
        .wb_rfen         (wb_cw[RFEN_BIT]),
        .wb_dest         (wb_dest),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_branch_taken (ex_branch_taken),
        .stall           (stall),
        .ifid_flush      (ifid_flush),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel)
    );

    assign bubble = stall || ifid_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_cw    <= '0;
            ex_dest  <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            mem_cw   <= '0;
            mem_dest <= '0;
            wb_cw    <= '0;
            wb_dest  <= '0;
        end else begin
            mem_cw   <= ex_cw;
            mem_dest <= ex_dest;
            wb_cw    <= mem_cw;
            wb_dest  <= mem_dest;
            if (bubble) begin
                ex_cw   <= '0;
                ex_dest <= '0;
                ex_rs   <= '0;
                ex_rt   <= '0;
            end else begin
                ex_cw   <= id_cw;
                ex_dest <= id_dest;
                ex_rs   <= id_rs;
                ex_rt   <= id_rt;
            end
        end
    end

    // A coincident flush and stall is accounted as a flush only
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (ifid_flush) begin
            if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end else if (stall) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
